// File: rtl/pipelined_cla_subtractor.sv
// Pipelined carry-lookahead subtractor: d = a - b - bin.
// One SIZE-bit lookahead group per stage, borrow registered between stages.
module pipelined_cla_subtractor #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int N = WIDTH / SIZE;

  logic [N-1:0]     vld;
  logic [N-1:0]     cr;
  logic [WIDTH-1:0] ar  [N];
  logic [WIDTH-1:0] nbr [N];
  logic [WIDTH-1:0] dr  [N];
  logic             bout_q;
  logic             ovf_q;

  logic [N-1:0]     load;
  logic [N-1:0]     sv;
  logic [N-1:0]     sc;
  logic [N-1:0]     nc;
  logic [WIDTH-1:0] sa  [N];
  logic [WIDTH-1:0] snb [N];
  logic [WIDTH-1:0] sd  [N];
  logic [WIDTH-1:0] nd  [N];
  logic [SIZE:0]    r;
  logic             rdy;
  logic             ovf_n;
  logic             unused;

  // Every carry of the group is a flat sum of generate/propagate products.
  function automatic logic [SIZE:0] cla(
    input logic [SIZE-1:0] x,
    input logic [SIZE-1:0] y,
    input logic            cin
  );
    logic [SIZE-1:0] g;
    logic [SIZE-1:0] p;
    logic [SIZE:0]   c;
    logic            t;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SIZE; i++) begin
      t = cin;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[SIZE], p ^ c[SIZE-1:0]};
  endfunction

  // Ready chain: a stage loads when empty or when it is draining.
  always_comb begin
    load = '0;
    rdy  = out_ready;
    for (int k = N - 1; k >= 0; k--) begin
      load[k] = !vld[k] || (vld[k] && rdy);
      rdy     = load[k];
    end
  end

  assign in_ready = load[0];

  always_comb begin
    r      = '0;
    nc     = '0;
    sa[0]  = a;
    snb[0] = ~b;
    sd[0]  = '0;
    sc[0]  = ~bin;
    sv[0]  = in_valid;
    for (int k = 1; k < N; k++) begin
      sa[k]  = ar[k-1];
      snb[k] = nbr[k-1];
      sd[k]  = dr[k-1];
      sc[k]  = cr[k-1];
      sv[k]  = vld[k-1];
    end
    for (int k = 0; k < N; k++) begin
      r = cla(sa[k][k*SIZE +: SIZE], snb[k][k*SIZE +: SIZE], sc[k]);
      nc[k] = r[SIZE];
      nd[k] = sd[k];
      nd[k][k*SIZE +: SIZE] = r[SIZE-1:0];
    end
  end

  assign ovf_n = (sa[N-1][WIDTH-1] == snb[N-1][WIDTH-1]) &&
                 (nd[N-1][WIDTH-1] != sa[N-1][WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      cr     <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        ar[k]  <= '0;
        nbr[k] <= '0;
        dr[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          vld[k] <= sv[k];
          if (sv[k]) begin
            ar[k]  <= sa[k];
            nbr[k] <= snb[k];
            dr[k]  <= nd[k];
            cr[k]  <= nc[k];
          end
        end
      end
      if (load[N-1] && sv[N-1]) begin
        bout_q <= ~nc[N-1];
        ovf_q  <= ovf_n;
      end
    end
  end

  assign out_valid = vld[N-1];
  assign d         = dr[N-1];
  assign bout      = bout_q;
  assign ovf       = ovf_q;

  // Last-stage operand copies are kept only for a uniform stage shape.
  assign unused = ^{ar[N-1], nbr[N-1], cr[N-1]};

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Scoreboard bench: 16/4 and 32/8 subtractors driven in lockstep.
module tb_pipelined_cla_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        bin = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic [31:0] a2 = '0, b2 = '0;
  logic        in_ready1, out_valid1, bout1, ovf1;
  logic        in_ready2, out_valid2, bout2, ovf2;
  logic [15:0] d1;
  logic [31:0] d2;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_cla_subtractor #(.WIDTH(16), .SIZE(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin), .out_valid(out_valid1),
    .out_ready(out_ready), .d(d1), .bout(bout1), .ovf(ovf1));

  pipelined_cla_subtractor #(.WIDTH(32), .SIZE(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a2), .b(b2), .bin(bin), .out_valid(out_valid2),
    .out_ready(out_ready), .d(d2), .bout(bout2), .ovf(ovf2));

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Plain integer arithmetic: unsigned for d/bout, signed range for ovf.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic bi, input int w);
    exp_t   e;
    longint ux, uy, sx, sy, u, s, m;
    m  = (64'sd1 <<< w);
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    u  = ux - uy - longint'({63'd0, bi});
    s  = sx - sy - longint'({63'd0, bi});
    e.bo = (u < 0);
    u    = (u < 0) ? u + m : u;
    e.d  = u[31:0];
    e.ov = (s >= m / 2) || (s < -(m / 2));
    return e;
  endfunction

  // One cycle of stimulus; expected in_ready follows from occupancy.
  task automatic drive(input logic iv, input logic ordy,
                       input logic [15:0] xa, input logic [15:0] xb,
                       input logic bi, input logic dir,
                       input logic [15:0] ed, input logic eb,
                       input logic eo, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    a1 = xa;
    b1 = xb;
    bin = bi;
    a2 = $urandom;
    b2 = $urandom;
    #1;
    chk("in_ready16", {63'd0, in_ready1},
        {63'd0, (q1.size() < 4) || ordy});
    chk("in_ready32", {63'd0, in_ready2},
        {63'd0, (q2.size() < 4) || ordy});
    acc = iv && in_ready1;
    if (acc) begin
      if (dir) begin
        e.d  = {16'd0, ed};
        e.bo = eb;
        e.ov = eo;
      end else begin
        e = model({16'd0, xa}, {16'd0, xb}, bi, 16);
      end
      q1.push_back(e);
      q2.push_back(model(a2, b2, bi, 32));
    end
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    drive(1'b0, ordy, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, acc);
  endtask

  // Directed op into an empty pipe; result must appear after N edges.
  task automatic directed(input logic [15:0] xa, input logic [15:0] xb,
                          input logic bi, input logic [15:0] ed,
                          input logic eb, input logic eo);
    logic acc;
    int   lat;
    drive(1'b1, 1'b1, xa, xb, bi, 1'b1, ed, eb, eo, acc);
    chk("dir_accept", {63'd0, acc}, 64'd1);
    lat = 0;
    do begin
      idle(1'b1);
      lat++;
    end while (!out_valid1 && lat < 20);
    chk("dir_latency", 64'(lat), 64'd4);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (q1.size() + q2.size()) != 0; k++)
      idle(1'b1);
    chk("drain_empty", 64'(q1.size() + q2.size()), 64'd0);
  endtask

  logic [15:0] hold1;
  logic [31:0] hold2;
  logic        held = 1'b0;

  // Monitor: pops one expectation per output transfer.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid1) begin
        chk("stall_hold16", {48'd0, d1}, {48'd0, hold1});
        chk("stall_hold32", {32'd0, d2}, {32'd0, hold2});
      end
      held  = out_valid1 && !out_ready;
      hold1 = d1;
      hold2 = d2;
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          chk("unexpected_out16", 64'd1, 64'd0);
        end else begin
          e = q1.pop_front();
          chk("result16", {46'd0, d1, bout1, ovf1},
              {46'd0, e.d[15:0], e.bo, e.ov});
        end
      end
      if (out_valid2 && out_ready) begin
        if (q2.size() == 0) begin
          chk("unexpected_out32", 64'd1, 64'd0);
        end else begin
          e = q2.pop_front();
          chk("result32", {30'd0, d2, bout2, ovf2},
              {30'd0, e.d, e.bo, e.ov});
        end
      end
    end
  end

  initial begin
    logic acc;
    logic iv, ordy;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid1}, 64'd0);
    chk("rst_d", {46'd0, d1, bout1, ovf1}, 64'd0);
    chk("rst_d32", {30'd0, d2, bout2, ovf2}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready1}, 64'd1);

    directed(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    directed(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    directed(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    directed(16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom),
            1'b0, 16'h0, 1'b0, 1'b0, acc);
      chk("stream_accept", {63'd0, acc}, 64'd1);
    end
    drain();

    for (int i = 0; i < 150; i++) begin
      iv   = ((i % 30) < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      ordy = ((i % 30) < 6) ? 1'b0 : ($urandom_range(0, 3) != 0);
      drive(iv, ordy, 16'($urandom), 16'($urandom), 1'($urandom),
            1'b0, 16'h0, 1'b0, 1'b0, acc);
      if ((i % 30) == 5)
        chk("stall_full", {63'd0, in_ready1}, 64'd0);
    end
    drain();

    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0,
            1'b0, 16'h0, 1'b0, 1'b0, acc);
    idle(1'b0);
    idle(1'b0);
    chk("pre_rst_valid", {63'd0, out_valid1}, 64'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {62'd0, out_valid1, out_valid2}, 64'd0);
    chk("mid_rst_d", {46'd0, d1, bout1, ovf1}, 64'd0);
    q1.delete();
    q2.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("post_rst_quiet", {63'd0, out_valid1}, 64'd0);
    end
    directed(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
